// File: rtl/peg_l2_mac_rx_framer_pkg.sv
// Shared constants, FSM encoding and helpers for the MAC RX framer.
// Imported by the framer top and its CRC-32 byte-step sub-module.
package peg_l2_mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam int          DLY_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } fsm_e;

    // Ethernet shifts LSB first, so the polynomial is applied bit-reversed.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/peg_l2_mac_rx_framer_if.sv
// Byte-wide packet stream with valid/sop/eop/error and ready back-pressure.
// master drives the beat, slave returns ready.
interface peg_l2_mac_rx_framer_if;
    logic       valid;
    logic       sop;
    logic       eop;
    logic [7:0] data;
    logic       error;
    logic       ready;

    modport master (output valid, sop, eop, data, error, input ready);
    modport slave  (input valid, sop, eop, data, error, output ready);
endinterface

// File: rtl/peg_l2_mac_rx_framer_crc32.sv
// peg_l2_crc32_d8: one-byte step of the reflected Ethernet CRC-32.
// Purely combinational; no final inversion is applied.
module peg_l2_crc32_d8
    import peg_l2_mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/peg_l2_mac_rx_framer.sv
// MAC RX framer: strips preamble/SFD and FCS, checks CRC and length, flags errors at eop.
// Optional saturating event counters are enabled with PEG_L2_MAC_RX_STATS_EN.
module peg_l2_mac_rx_framer
    import peg_l2_mac_pkg::*;
#(
    parameter int unsigned MIN_FRM_LEN = 64,
    parameter int unsigned MAX_FRM_LEN = 1518
) (
    input  logic                          clk,
    input  logic                          rst,
    peg_l2_mac_rx_framer_if.slave         pkt_in,
    peg_l2_mac_rx_framer_if.master        pkt_out,
    output logic                          stat_frm_ok,
    output logic                          stat_crc_err,
    output logic                          stat_len_err,
    output logic                          stat_pre_err
`ifdef PEG_L2_MAC_RX_STATS_EN
    ,
    output logic [15:0]                   stat_cnt_ok,
    output logic [15:0]                   stat_cnt_crc,
    output logic [15:0]                   stat_cnt_len,
    output logic [15:0]                   stat_cnt_pre
`endif
);

    fsm_e        state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_calc;
    logic [15:0] len_q, len_d, len_inc;
    logic [2:0]  dly_cnt_q, dly_cnt_d;
    logic        sop_sent_q, sop_sent_d;
    logic        sticky_q, sticky_d;
    logic        shift_en;
    logic [7:0]  dly_oldest;

    logic        out_valid_q, out_sop_q, out_eop_q, out_err_q;
    logic [7:0]  out_data_q;
    logic        ld, ld_sop, ld_eop, ld_err;

    // Pulse vector order: {pre, len, crc, ok}
    logic [3:0]  stat_q, stat_d;

    logic        in_ready, accept, restart;
    logic        crc_bad, len_bad, dly_full;

    peg_l2_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (pkt_in.data),
        .crc_out (crc_calc)
    );

    assign in_ready = ~out_valid_q | pkt_out.ready;
    assign accept   = pkt_in.valid & in_ready;
    assign len_inc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign len_bad  = (32'(len_inc) < MIN_FRM_LEN) || (32'(len_inc) > MAX_FRM_LEN);
    assign crc_bad  = (crc_calc != CRC32_RESIDUE);
    assign dly_full = (dly_cnt_q == 3'(DLY_DEPTH));

    // Four-stage delay line hides the FCS: stage 0 takes the new byte, stage 3 is oldest.
    generate
        for (genvar gi = 0; gi < DLY_DEPTH; gi++) begin : g_dly
            logic [7:0] stage_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q <= 8'h00;
                end else if (shift_en) begin
                    if (gi == 0) begin
                        stage_q <= pkt_in.data;
                    end else begin
                        stage_q <= g_dly[(gi == 0) ? 0 : gi-1].stage_q;
                    end
                end
            end
        end
    endgenerate

    assign dly_oldest = g_dly[DLY_DEPTH-1].stage_q;

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        dly_cnt_d  = dly_cnt_q;
        sop_sent_d = sop_sent_q;
        sticky_d   = sticky_q;
        shift_en   = 1'b0;
        ld         = 1'b0;
        ld_sop     = 1'b0;
        ld_eop     = 1'b0;
        ld_err     = 1'b0;
        stat_d     = 4'b0000;
        restart    = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: restart = pkt_in.sop;
                PRE: begin
                    if (pkt_in.sop) begin
                        restart = 1'b1;
                    end else if (pkt_in.eop) begin
                        state_d = IDLE;
                    end else if (pkt_in.data == SFD_BYTE) begin
                        state_d    = DATA;
                        crc_d      = CRC32_INIT;
                        len_d      = 16'd0;
                        dly_cnt_d  = 3'd0;
                        sop_sent_d = 1'b0;
                        sticky_d   = 1'b0;
                    end else if (pkt_in.data != PREAMBLE_BYTE) begin
                        state_d   = DROP;
                        stat_d[3] = 1'b1;
                    end
                end
                DROP: begin
                    if (pkt_in.sop) begin
                        restart = 1'b1;
                    end else if (pkt_in.eop) begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (pkt_in.sop) begin
                        // Missing eop: close the frame already started downstream as bad.
                        restart = 1'b1;
                        if (sop_sent_q) begin
                            ld        = 1'b1;
                            ld_eop    = 1'b1;
                            ld_err    = 1'b1;
                            stat_d[2] = 1'b1;
                        end
                    end else begin
                        crc_d    = crc_calc;
                        len_d    = len_inc;
                        shift_en = 1'b1;
                        sticky_d = sticky_q | pkt_in.error;
                        if (dly_full) begin
                            ld         = 1'b1;
                            ld_sop     = ~sop_sent_q;
                            sop_sent_d = 1'b1;
                        end else begin
                            dly_cnt_d = dly_cnt_q + 3'd1;
                        end
                        if (pkt_in.eop) begin
                            state_d = IDLE;
                            if (!dly_full) begin
                                stat_d[2] = 1'b1;
                            end else begin
                                ld_eop = 1'b1;
                                ld_err = crc_bad | len_bad | sticky_d;
                                // A PHY error with an intact FCS is still an integrity failure.
                                if (len_bad) begin
                                    stat_d[2] = 1'b1;
                                end else if (crc_bad | sticky_d) begin
                                    stat_d[1] = 1'b1;
                                end else begin
                                    stat_d[0] = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (restart) begin
                if (pkt_in.data == PREAMBLE_BYTE) begin
                    state_d = pkt_in.eop ? IDLE : PRE;
                end else begin
                    state_d   = pkt_in.eop ? IDLE : DROP;
                    stat_d[3] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            crc_q      <= CRC32_INIT;
            len_q      <= 16'd0;
            dly_cnt_q  <= 3'd0;
            sop_sent_q <= 1'b0;
            sticky_q   <= 1'b0;
            stat_q     <= 4'b0000;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            dly_cnt_q  <= dly_cnt_d;
            sop_sent_q <= sop_sent_d;
            sticky_q   <= sticky_d;
            stat_q     <= stat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= 8'h00;
        end else if (ld) begin
            out_valid_q <= 1'b1;
            out_sop_q   <= ld_sop;
            out_eop_q   <= ld_eop;
            out_err_q   <= ld_err;
            out_data_q  <= dly_oldest;
        end else if (pkt_out.ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign pkt_in.ready  = in_ready;
    assign pkt_out.valid = out_valid_q;
    assign pkt_out.sop   = out_sop_q;
    assign pkt_out.eop   = out_eop_q;
    assign pkt_out.error = out_err_q;
    assign pkt_out.data  = out_data_q;

    assign stat_frm_ok  = stat_q[0];
    assign stat_crc_err = stat_q[1];
    assign stat_len_err = stat_q[2];
    assign stat_pre_err = stat_q[3];

`ifdef PEG_L2_MAC_RX_STATS_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [15:0] cnt_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= 16'd0;
                end else if (stat_q[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    endgenerate

    assign stat_cnt_ok  = g_cnt[0].cnt_q;
    assign stat_cnt_crc = g_cnt[1].cnt_q;
    assign stat_cnt_len = g_cnt[2].cnt_q;
    assign stat_cnt_pre = g_cnt[3].cnt_q;
`endif

endmodule

// File: tb/tb_peg_l2_mac_rx_framer.sv
// Directed bench for peg_l2_mac_rx_framer: good/CRC/length/preamble/abort frames,
// random output back-pressure, one line per frame-level transaction.
module tb_peg_l2_mac_rx_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    peg_l2_mac_rx_framer_if in_if ();
    peg_l2_mac_rx_framer_if out_if ();

    logic stat_ok, stat_crc, stat_len, stat_pre;
`ifdef PEG_L2_MAC_RX_STATS_EN
    logic [15:0] cnt_ok, cnt_crc, cnt_len, cnt_pre;
`endif

    peg_l2_mac_rx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_in       (in_if),
        .pkt_out      (out_if),
        .stat_frm_ok  (stat_ok),
        .stat_crc_err (stat_crc),
        .stat_len_err (stat_len),
        .stat_pre_err (stat_pre)
`ifdef PEG_L2_MAC_RX_STATS_EN
        ,
        .stat_cnt_ok  (cnt_ok),
        .stat_cnt_crc (cnt_crc),
        .stat_cnt_len (cnt_len),
        .stat_cnt_pre (cnt_pre)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] bd[$];
    bit         bs[$];
    bit         be[$];
    logic [7:0] exp_q[$];
    logic [7:0] od[$];
    bit         os[$];
    bit         oe[$];
    bit         ox[$];
    int n_ok, n_crc, n_len, n_pre;
    bit rand_rdy = 1'b0;

    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_if.valid && out_if.ready) begin
                    od.push_back(out_if.data);
                    os.push_back(out_if.sop);
                    oe.push_back(out_if.eop);
                    ox.push_back(out_if.error);
                end
                if (stat_ok)  n_ok++;
                if (stat_crc) n_crc++;
                if (stat_len) n_len++;
                if (stat_pre) n_pre++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2ms", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic int data_mism();
        int m = 0;
        for (int i = 0; i < od.size() && i < exp_q.size(); i++)
            if (od[i] !== exp_q[i]) m++;
        return m;
    endfunction

    function automatic int n_sop();
        int n = 0;
        foreach (os[i]) if (os[i]) n++;
        return n;
    endfunction

    function automatic int n_eop();
        int n = 0;
        foreach (oe[i]) if (oe[i]) n++;
        return n;
    endfunction

    function automatic bit last_eop();
        return (oe.size() > 0) ? oe[oe.size()-1] : 1'b0;
    endfunction

    function automatic bit last_err();
        return (ox.size() > 0) ? ox[ox.size()-1] : 1'b0;
    endfunction

    task automatic add_beat(input logic [7:0] d, input bit s, input bit e);
        bd.push_back(d);
        bs.push_back(s);
        be.push_back(e);
    endtask

    // Preamble+SFD, n bytes DA..payload, then FCS when close=1.
    // Unclosed frames are aborted later: n-4 bytes stream plus one released on abort.
    task automatic add_frame(input int n, input int seed, input int flip, input bit close);
        logic [7:0] p[$];
        logic [31:0] c;
        logic [31:0] fcs;
        int keep;
        add_beat(8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) add_beat(8'h55, 1'b0, 1'b0);
        add_beat(8'hD5, 1'b0, 1'b0);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            p.push_back(8'(i * 37 + seed));
            c = crc_upd(c, p[i]);
        end
        if (flip >= 0) p[flip] = p[flip] ^ 8'h10;
        keep = close ? n : n - 3;
        for (int i = 0; i < n; i++) begin
            add_beat(p[i], 1'b0, 1'b0);
            if (i < keep) exp_q.push_back(p[i]);
        end
        if (close) begin
            fcs = ~c;
            for (int k = 0; k < 4; k++) add_beat(fcs[8*k +: 8], 1'b0, (k == 3));
        end
    endtask

    task automatic clear_obs();
        bd.delete(); bs.delete(); be.delete(); exp_q.delete();
        od.delete(); os.delete(); oe.delete(); ox.delete();
        n_ok = 0; n_crc = 0; n_len = 0; n_pre = 0;
    endtask

    task automatic drive_all();
        int t;
        bit done;
        @(posedge clk);
        #1;
        for (int b = 0; b < bd.size(); b++) begin
            in_if.valid = 1'b1;
            in_if.data  = bd[b];
            in_if.sop   = bs[b];
            in_if.eop   = be[b];
            in_if.error = 1'b0;
            t = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (in_if.ready) begin
                    done = 1'b1;
                end else begin
                    t++;
                    if (t > 200) begin
                        checks++;
                        failures++;
                        $display("FAIL in_ready_timeout: ready=%0b for %0d cycles, required 1", in_if.ready, t);
                        done = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        rand_rdy    = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
        in_if.data = 8'h00; in_if.error = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_if.valid, out_if.sop, out_if.eop, out_if.error} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_out_ctrl: got %b required 0000", {out_if.valid, out_if.sop, out_if.eop, out_if.error});
        end
        checks++;
        if (out_if.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_data: got %h required 00", out_if.data);
        end
        checks++;
        if ({stat_ok, stat_crc, stat_len, stat_pre} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_stats: got %b required 0000", {stat_ok, stat_crc, stat_len, stat_pre});
        end
        checks++;
        if (in_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_if.ready);
        end
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic check_good(input string tag, input int n);
        checks++;
        if (od.size() !== n) begin
            failures++;
            $display("FAIL %s_count: got %0d bytes required %0d", tag, od.size(), n);
        end
        checks++;
        if (data_mism() !== 0) begin
            failures++;
            $display("FAIL %s_data: got %0d mismatched bytes required 0", tag, data_mism());
        end
        checks++;
        if (n_sop() !== 1 || os.size() == 0 || os[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_sop: got %0d sop beats required 1 on first byte", tag, n_sop());
        end
        checks++;
        if (n_eop() !== 1 || last_eop() !== 1'b1) begin
            failures++;
            $display("FAIL %s_eop: got %0d eop beats (last=%0b) required 1 on last byte", tag, n_eop(), last_eop());
        end
    endtask

    task automatic check_stats(input string tag, input int ok, input int crc, input int len, input int pre);
        checks++;
        if (n_ok !== ok || n_crc !== crc || n_len !== len || n_pre !== pre) begin
            failures++;
            $display("FAIL %s_stats: got ok=%0d crc=%0d len=%0d pre=%0d required ok=%0d crc=%0d len=%0d pre=%0d",
                     tag, n_ok, n_crc, n_len, n_pre, ok, crc, len, pre);
        end
    endtask

    task automatic check_err(input string tag, input bit e);
        checks++;
        if (last_err() !== e) begin
            failures++;
            $display("FAIL %s_error: got %0b required %0b", tag, last_err(), e);
        end
    endtask

    task automatic test_good_frame();
        clear_obs();
        add_frame(60, 3, -1, 1);
        drive_all();
        check_good("good", 60);
        check_err("good", 1'b0);
        check_stats("good", 1, 0, 0, 0);
        $display("test_good_frame: %0d bytes out", od.size());
    endtask

    task automatic test_crc_err();
        clear_obs();
        add_frame(60, 3, 30, 1);
        drive_all();
        check_good("crc", 60);
        check_err("crc", 1'b1);
        check_stats("crc", 0, 1, 0, 0);
        $display("test_crc_err: %0d bytes out", od.size());
    endtask

    task automatic test_runt();
        clear_obs();
        add_frame(36, 9, -1, 1);
        drive_all();
        check_good("runt", 36);
        check_err("runt", 1'b1);
        check_stats("runt", 0, 0, 1, 0);
        $display("test_runt: %0d bytes out", od.size());
    endtask

    task automatic test_oversize();
        clear_obs();
        add_frame(1515, 5, -1, 1);
        drive_all();
        check_good("oversize", 1515);
        check_err("oversize", 1'b1);
        check_stats("oversize", 0, 0, 1, 0);
        $display("test_oversize: %0d bytes out", od.size());
    endtask

    task automatic test_tiny();
        clear_obs();
        add_frame(0, 0, -1, 1);
        drive_all();
        checks++;
        if (od.size() !== 0) begin
            failures++;
            $display("FAIL tiny_count: got %0d bytes required 0", od.size());
        end
        check_stats("tiny", 0, 0, 1, 0);
        $display("test_tiny: %0d bytes out", od.size());
    endtask

    task automatic test_bad_preamble();
        clear_obs();
        add_beat(8'h55, 1'b1, 1'b0);
        add_beat(8'h55, 1'b0, 1'b0);
        add_beat(8'hAA, 1'b0, 1'b0);
        add_beat(8'h01, 1'b0, 1'b0);
        add_beat(8'h02, 1'b0, 1'b0);
        add_beat(8'h03, 1'b0, 1'b1);
        drive_all();
        checks++;
        if (od.size() !== 0) begin
            failures++;
            $display("FAIL pre_count: got %0d bytes required 0", od.size());
        end
        check_stats("pre", 0, 0, 0, 1);
        bd.delete(); bs.delete(); be.delete();
        add_frame(60, 17, -1, 1);
        drive_all();
        check_good("pre_next", 60);
        check_err("pre_next", 1'b0);
        check_stats("pre_next", 1, 0, 0, 1);
        $display("test_bad_preamble: %0d bytes out after drop", od.size());
    endtask

    task automatic test_ready_toggle();
        clear_obs();
        add_frame(60, 3, -1, 1);
        rand_rdy = 1'b1;
        drive_all();
        check_good("toggle", 60);
        check_err("toggle", 1'b0);
        check_stats("toggle", 1, 0, 0, 0);
        $display("test_ready_toggle: %0d bytes out", od.size());
    endtask

    task automatic test_abort();
        clear_obs();
        add_frame(19, 11, -1, 0);
        add_frame(60, 23, -1, 1);
        drive_all();
        checks++;
        if (od.size() !== 76) begin
            failures++;
            $display("FAIL abort_count: got %0d bytes required 76", od.size());
        end
        checks++;
        if (data_mism() !== 0) begin
            failures++;
            $display("FAIL abort_data: got %0d mismatched bytes required 0", data_mism());
        end
        checks++;
        if (od.size() < 17 || oe[15] !== 1'b1 || ox[15] !== 1'b1 || os[16] !== 1'b1) begin
            failures++;
            $display("FAIL abort_close: got %0d bytes, eop/err at 16th byte not as required (eop=1 err=1, next sop=1)", od.size());
        end
        checks++;
        if (n_sop() !== 2 || n_eop() !== 2) begin
            failures++;
            $display("FAIL abort_marks: got sop=%0d eop=%0d required 2 and 2", n_sop(), n_eop());
        end
        check_err("abort_next", 1'b0);
        check_stats("abort", 1, 0, 1, 0);
        $display("test_abort: %0d bytes out", od.size());
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_err();
        test_runt();
        test_oversize();
        test_tiny();
        test_bad_preamble();
        test_ready_toggle();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
